// File: rtl/reset_sequencer.sv
// reset_sequencer: per-clock-domain reset generator. Asynchronous assert,
// synchronous de-assert, then waits for a synchronized clock-lock, holds all
// outputs for HOLD_CYCLES and releases NUM_OUT reset lines one at a time,
// STAGE_GAP cycles apart, flagging rst_done once everything is out of reset.
// Loss of lock or a software request pulls every line back into reset.
module reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int NUM_OUT     = 3,
    parameter int STAGE_GAP   = 4
) (
    input  logic               clk,
    input  logic               ar,
    input  logic               lock,
    input  logic               sw_req,
    output logic [NUM_OUT-1:0] rst_out,
    output logic               rst_done,
    output logic [1:0]         state
);

    localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(NUM_OUT + 1);

    typedef enum logic [2:0] {
        S_RESET,
        S_WAIT_LOCK,
        S_HOLD,
        S_RELEASE,
        S_RUN
    } state_e;

    logic [SYNC_STAGES-1:0] rst_sync_q;
    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic                   rst_int;
    logic                   lock_s;
    logic                   abort;

    state_e                 state_q,    state_d;
    logic [CNT_W-1:0]       cnt_q,      cnt_d;
    logic [IDX_W-1:0]       idx_q,      idx_d;
    logic [NUM_OUT-1:0]     rst_out_q,  rst_out_d;
    logic                   rst_done_q, rst_done_d;

    // Synchronizers: internal reset de-asserts through a 0-fed chain; lock is resampled into clk.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge ar) begin
        if (ar) begin
            rst_sync_q  <= '1;
            lock_sync_q <= '0;
        end else begin
            rst_sync_q  <= {rst_sync_q[SYNC_STAGES-2:0], 1'b0};
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], lock};
        end
    end

    assign rst_int = rst_sync_q[SYNC_STAGES-1];
    assign lock_s  = lock_sync_q[SYNC_STAGES-1];

    // Sequencer state register; outputs come straight from these flops.
    always_ff @(posedge clk or posedge ar) begin
        if (ar) begin
            state_q    <= S_RESET;
            cnt_q      <= '0;
            idx_q      <= '0;
            rst_out_q  <= '1;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            rst_out_q  <= rst_out_d;
            rst_done_q <= rst_done_d;
        end
    end

    // Next-state logic: abort has priority over every sequencing step.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        rst_out_d  = rst_out_q;
        rst_done_d = rst_done_q;
        abort      = (state_q != S_RESET) && (!lock_s || sw_req);

        if (abort) begin
            state_d    = S_WAIT_LOCK;
            cnt_d      = '0;
            idx_d      = '0;
            rst_out_d  = '1;
            rst_done_d = 1'b0;
        end else begin
            case (state_q)
                S_RESET: begin
                    if (!rst_int) begin
                        state_d = S_WAIT_LOCK;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                    end
                end
                S_HOLD: begin
                    if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                        state_d   = S_RELEASE;
                        cnt_d     = '0;
                        idx_d     = '0;
                        // Released bits are a contiguous low run, so shifting in a 0
                        // drops exactly the next line in index order.
                        rst_out_d = rst_out_q << 1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
                        cnt_d = '0;
                        if (idx_q < IDX_W'(NUM_OUT - 1)) begin
                            idx_d     = idx_q + IDX_W'(1);
                            rst_out_d = rst_out_q << 1;
                        end else begin
                            state_d    = S_RUN;
                            rst_done_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    rst_out_d  = '0;
                    rst_done_d = 1'b1;
                end
                default: begin
                    state_d = S_RESET;
                end
            endcase
        end
    end

    // Debug encoding merges HOLD and RELEASE into a single code.
    always_comb begin
        case (state_q)
            S_RESET:     state = 2'd0;
            S_WAIT_LOCK: state = 2'd1;
            S_HOLD:      state = 2'd2;
            S_RELEASE:   state = 2'd2;
            S_RUN:       state = 2'd3;
            default:     state = 2'd0;
        endcase
    end

    assign rst_out  = rst_out_q;
    assign rst_done = rst_done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: randomized and directed stimulus against a timeline
// reference model. The model tracks only the phase (reset / waiting / sequencing)
// and the elapsed cycles since hold began; outputs are computed from that time.
module tb_reset_sequencer;

    localparam int SYNC_STAGES = 2;
    localparam int HOLD_CYCLES = 16;
    localparam int NUM_OUT     = 3;
    localparam int STAGE_GAP   = 4;
    localparam int SEQ_LEN     = HOLD_CYCLES + NUM_OUT * STAGE_GAP;

    logic               clk = 1'b0;
    logic               ar;
    logic               lock;
    logic               sw_req;
    logic [NUM_OUT-1:0] rst_out;
    logic               rst_done;
    logic [1:0]         state;

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0 = reset, 1 = waiting for lock, 2 = sequencing.
    int                     m_phase;
    int                     m_edges;
    int                     m_t;
    logic [SYNC_STAGES-1:0] m_lock_hist;

    reset_sequencer #(
        .SYNC_STAGES(SYNC_STAGES),
        .HOLD_CYCLES(HOLD_CYCLES),
        .NUM_OUT    (NUM_OUT),
        .STAGE_GAP  (STAGE_GAP)
    ) dut (
        .clk     (clk),
        .ar      (ar),
        .lock    (lock),
        .sw_req  (sw_req),
        .rst_out (rst_out),
        .rst_done(rst_done),
        .state   (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase     = 0;
        m_edges     = 0;
        m_t         = 0;
        m_lock_hist = '0;
    endtask

    // One rising edge of the model, using input values present before the edge.
    task automatic model_edge();
        logic ls;
        if (ar) return;
        ls = m_lock_hist[SYNC_STAGES-1];
        if (m_phase == 0) begin
            if (m_edges >= SYNC_STAGES) m_phase = 1;
        end else if (!ls || sw_req) begin
            m_phase = 1;
            m_t     = 0;
        end else if (m_phase == 1) begin
            m_phase = 2;
            m_t     = 0;
        end else if (m_t < SEQ_LEN) begin
            m_t++;
        end
        m_lock_hist = {m_lock_hist[SYNC_STAGES-2:0], lock};
        if (m_edges < 100000) m_edges++;
    endtask

    task automatic compare_all(input string tag);
        logic [NUM_OUT-1:0] exp_out;
        logic [NUM_OUT-1:0] rel;
        logic               exp_done;
        logic [1:0]         exp_state;
        exp_out   = '1;
        exp_done  = 1'b0;
        exp_state = 2'(m_phase);
        if (m_phase == 2) begin
            for (int i = 0; i < NUM_OUT; i++) exp_out[i] = (m_t < HOLD_CYCLES + i * STAGE_GAP);
            exp_done  = (m_t >= SEQ_LEN);
            exp_state = exp_done ? 2'd3 : 2'd2;
        end
        check({tag, "_out"},   32'(rst_out),   32'(exp_out));
        check({tag, "_done"},  32'(rst_done),  32'(exp_done));
        check({tag, "_state"}, 32'(state),     32'(exp_state));
        rel = ~rst_out;
        check({tag, "_order"}, 32'((rel & (rel + 1'b1)) == '0), 32'd1);
    endtask

    // Called at a falling edge: drive inputs, take one rising edge, compare at the next falling edge.
    task automatic cycle(input string tag, input logic l, input logic s);
        lock   = l;
        sw_req = s;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all(tag);
    endtask

    // Called at a falling edge: assert ar between clocks, check the immediate effect, release.
    task automatic pulse_ar(input logic l);
        #2;
        ar     = 1'b1;
        lock   = l;
        sw_req = 1'b0;
        model_reset();
        #1;
        compare_all("ar_async");
        @(posedge clk);
        @(negedge clk);
        compare_all("ar_held");
        ar = 1'b0;
    endtask

    // Runs the power-up timeline and checks the absolute edge of each release.
    task automatic timeline(input string tag);
        int e110, e100, e000, edone;
        e110 = -1; e100 = -1; e000 = -1; edone = -1;
        for (int n = 1; n <= 34; n++) begin
            cycle(tag, 1'b1, 1'b0);
            if (rst_out == 3'b110 && e110 < 0) e110 = n;
            if (rst_out == 3'b100 && e100 < 0) e100 = n;
            if (rst_out == 3'b000 && e000 < 0) e000 = n;
            if (rst_done && edone < 0) edone = n;
        end
        check({tag, "_edge_rel0"}, 32'(e110),  32'd20);
        check({tag, "_edge_rel1"}, 32'(e100),  32'd24);
        check({tag, "_edge_rel2"}, 32'(e000),  32'd28);
        check({tag, "_edge_done"}, 32'(edone), 32'd32);
    endtask

    initial begin
        int cnt;
        ar     = 1'b1;
        lock   = 1'b1;
        sw_req = 1'b0;
        model_reset();

        // Power-up
        @(negedge clk);
        compare_all("por");
        @(negedge clk);
        compare_all("por_hold");
        ar = 1'b0;
        timeline("t1");

        // ar asserted mid-sequence (after edge 22), then a clean restart
        pulse_ar(1'b1);
        for (int n = 0; n < 22; n++) cycle("t2_pre", 1'b1, 1'b0);
        pulse_ar(1'b1);
        timeline("t2");

        // Lock drops for one cycle while running
        lock = 1'b0;
        cnt  = 0;
        for (int n = 1; n <= 6; n++) begin
            cycle("t3_drop", (n == 1) ? 1'b0 : 1'b1, 1'b0);
            if (rst_out == 3'b111 && cnt == 0) cnt = n;
        end
        check("t3_abort_within", 32'(cnt >= 1 && cnt <= SYNC_STAGES + 1), 32'd1);
        for (int n = 0; n < 40; n++) cycle("t3_rerun", 1'b1, 1'b0);
        check("t3_done_again", 32'(rst_done), 32'd1);

        // Software request pulse while running
        cycle("t4_pulse", 1'b1, 1'b1);
        check("t4_asserted", 32'(rst_out), 32'h7);
        for (int n = 0; n < 32; n++) cycle("t4_rerun", 1'b1, 1'b0);

        // No lock at power-up, then lock arrives
        pulse_ar(1'b0);
        for (int n = 0; n < 12; n++) cycle("t5_nolock", 1'b0, 1'b0);
        check("t5_waiting", 32'(state), 32'd1);
        cnt = -1;
        for (int n = 1; n <= 40 && cnt < 0; n++) begin
            cycle("t5_lock", 1'b1, 1'b0);
            if (!rst_out[0]) cnt = n;
        end
        check("t5_rel0_delay", 32'(cnt), 32'(1 + SYNC_STAGES + HOLD_CYCLES));

        // Abort (sw_req + lock loss) coinciding with the rst_out[1] release at edge 24
        pulse_ar(1'b1);
        for (int n = 1; n <= 21; n++) cycle("t6_pre", 1'b1, 1'b0);
        cycle("t6_pre", 1'b0, 1'b0);
        cycle("t6_pre", 1'b0, 1'b0);
        check("t6_before", 32'(rst_out), 32'h6);
        cycle("t6_abort", 1'b0, 1'b1);
        check("t6_suppressed", 32'(rst_out), 32'h7);
        for (int n = 0; n < 8; n++) cycle("t6_nolock", 1'b0, 1'b0);
        for (int n = 0; n < 34; n++) cycle("t6_rerun", 1'b1, 1'b0);

        // Held sw_req keeps the block waiting
        for (int n = 0; n < 10; n++) cycle("sw_held", 1'b1, 1'b1);
        check("sw_held_state", 32'(state), 32'd1);

        // Randomized traffic: rare lock drops, sw requests and ar pulses
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                pulse_ar(1'($urandom_range(0, 1)));
            end else begin
                cycle("rand", 1'($urandom_range(0, 99) < 98), 1'($urandom_range(0, 249) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
